// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: one-stage pipeline register with a skid buffer so in_ready is registered,
// plus saturating stall/bubble counters.
module pipe_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    logic in_xfer, out_xfer;
    // in_ready depends only on stored state (and reset), never on out_ready
    assign in_ready   = (state_q != SKID) && !rst;
    assign out_valid  = state_q != EMPTY;
    assign out_data   = main_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_d = FULL;
                    main_d  = in_data;
                end
                FULL: if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    state_d = SKID;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end
                SKID: if (out_xfer) begin
                    state_d = FULL;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end
    always_comb begin
        stall_d  = clr_cnt ? '0 : (out_valid && !out_ready && stall_q != CNT_MAX) ? stall_q + 1'b1 : stall_q;
        bubble_d = clr_cnt ? '0 : (!out_valid && bubble_q != CNT_MAX) ? bubble_q + 1'b1 : bubble_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end
endmodule
